// File: rtl/qwi_regarb_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encodings and index-width helper.
package qwi_regarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/qwi_rr_pick.sv
// Combinational rotating-priority selector: first asserted request at or after ptr wins.
module qwi_rr_pick
    import qwi_regarb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    logic [2*NREQ-1:0] dbl;
    logic [PW:0]       sum;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        // Doubling the vector turns the wrap-around search into a plain shift.
        dbl     = {req, req} >> ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && dbl[i]) begin
                gnt_vld = 1'b1;
                sum     = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
                gnt_idx = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/qwi_regarb.sv
// Serialises NREQ single-word req/ack transactions onto one register-bank port.
// Define REGARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
//
// state     | meaning
// ST_IDLE   | waiting for a request; winner's fields captured on exit
// ST_ACCESS | one bank cycle with reg_ce=1; bank read data captured at its end
// ST_ACK    | one-cycle req_ack pulse to the winner; pointer advances
module qwi_regarb
    import qwi_regarb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AWID = 12,
    parameter int DWID = 32
) (
    input  logic                   reg_clk,
    input  logic                   sys_rst,
    input  logic [NREQ-1:0]        req_vld,
    input  logic [NREQ*DWID/8-1:0] req_we,
    input  logic [NREQ*AWID-1:0]   req_addr,
    input  logic [NREQ*DWID-1:0]   req_wrd,
    output logic [NREQ-1:0]        req_ack,
    output logic [DWID-1:0]        req_rdd,
    output logic                   reg_ce,
    output logic [DWID/8-1:0]      reg_we,
    output logic [AWID-1:0]        reg_addr,
    output logic [DWID-1:0]        reg_wrd,
    input  logic [DWID-1:0]        reg_rdd
);

    localparam int BW = DWID / 8;
    localparam int PW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   win_q, win_d;
    logic [BW-1:0]   we_q, we_d;
    logic [AWID-1:0] addr_q, addr_d;
    logic [DWID-1:0] wrd_q, wrd_d;
    logic [DWID-1:0] rdd_q, rdd_d;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_vld;

    qwi_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (req_vld),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

`ifdef REGARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_ACK) begin
            ptr_d = (win_q == PW'(NREQ-1)) ? '0 : win_q + PW'(1);
        end
    end

    always_ff @(posedge reg_clk or posedge sys_rst) begin
        if (sys_rst) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wrd_d   = wrd_q;
        rdd_d   = rdd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_ACCESS;
                    win_d   = pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_idx == PW'(i)) begin
                            we_d   = req_we[i*BW +: BW];
                            addr_d = req_addr[i*AWID +: AWID];
                            wrd_d  = req_wrd[i*DWID +: DWID];
                        end
                    end
                end
            end
            ST_ACCESS: begin
                rdd_d   = reg_rdd;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wrd_q   <= '0;
            rdd_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wrd_q   <= wrd_d;
            rdd_q   <= rdd_d;
        end
    end

    // Address and write data stay on the bus between accesses; only ce/we are gated.
    assign reg_ce   = (state_q == ST_ACCESS);
    assign reg_we   = reg_ce ? we_q : '0;
    assign reg_addr = addr_q;
    assign reg_wrd  = wrd_q;
    assign req_rdd  = rdd_q;

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ack[i] = (state_q == ST_ACK) && (win_q == PW'(i));
        end
    end

endmodule

// File: tb/tb_qwi_regarb.sv
// Self-checking bench for qwi_regarb with a small behavioural register bank.
module tb_qwi_regarb;

    localparam int NREQ = 2;
    localparam int AWID = 12;
    localparam int DWID = 32;
    localparam int BW   = DWID / 8;

    logic                 reg_clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic [NREQ-1:0]      req_vld = '0;
    logic [NREQ*BW-1:0]   req_we = '0;
    logic [NREQ*AWID-1:0] req_addr = '0;
    logic [NREQ*DWID-1:0] req_wrd = '0;
    logic [NREQ-1:0]      req_ack;
    logic [DWID-1:0]      req_rdd;
    logic                 reg_ce;
    logic [BW-1:0]        reg_we;
    logic [AWID-1:0]      reg_addr;
    logic [DWID-1:0]      reg_wrd;
    logic [DWID-1:0]      reg_rdd;

    always #5 reg_clk = ~reg_clk;

    qwi_regarb #(
        .NREQ (NREQ),
        .AWID (AWID),
        .DWID (DWID)
    ) dut (
        .reg_clk  (reg_clk),
        .sys_rst  (sys_rst),
        .req_vld  (req_vld),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wrd  (req_wrd),
        .req_ack  (req_ack),
        .req_rdd  (req_rdd),
        .reg_ce   (reg_ce),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_wrd  (reg_wrd),
        .reg_rdd  (reg_rdd)
    );

    // Bank: combinational read, commits only on all-ones byte enables.
    logic [DWID-1:0] mem [16] = '{default: '0};
    logic            pl_en = 1'b0;
    logic [3:0]      pl_addr = '0;
    logic [DWID-1:0] pl_data = '0;

    assign reg_rdd = mem[reg_addr[3:0]];

    always @(posedge reg_clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (reg_ce && reg_we == {BW{1'b1}}) mem[reg_addr[3:0]] <= reg_wrd;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [DWID-1:0] shadow [16];

    typedef struct {
        int              idx;
        logic [DWID-1:0] rdd;
        bit              chk;
    } exp_t;
    exp_t sb[$];

    task automatic preload(input logic [3:0] a, input logic [DWID-1:0] d);
        @(posedge reg_clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
        @(posedge reg_clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic drive_req(input int idx, input logic [BW-1:0] we,
                             input logic [AWID-1:0] addr, input logic [DWID-1:0] wrd);
        req_we[idx*BW +: BW]       = we;
        req_addr[idx*AWID +: AWID] = addr;
        req_wrd[idx*DWID +: DWID]  = wrd;
        req_vld[idx]               = 1'b1;
    endtask

    task automatic single_txn(input string nm, input int idx, input logic [BW-1:0] we,
                              input logic [AWID-1:0] addr, input logic [DWID-1:0] wrd,
                              input bit early_drop);
        exp_t e;
        exp_t got_e;
        int n, ce_n;
        bit got;
        logic [NREQ-1:0] exp_ack;
        e.idx = idx;
        e.chk = (we == '0);
        e.rdd = shadow[addr[3:0]];
        if (we == {BW{1'b1}}) shadow[addr[3:0]] = wrd;
        sb.push_back(e);
        @(posedge reg_clk); #1;
        drive_req(idx, we, addr, wrd);
        n = 0; ce_n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge reg_clk);
            n++;
            if (reg_ce) begin
                ce_n++;
                vectors++;
                if (reg_we !== we || reg_addr !== addr || reg_wrd !== wrd) begin
                    miscompares++;
                    $display("FAIL %s bus: got we=%h addr=%h wrd=%h want we=%h addr=%h wrd=%h",
                             nm, reg_we, reg_addr, reg_wrd, we, addr, wrd);
                end
            end
            if (early_drop && n == 2) req_vld[idx] = 1'b0;
            if (req_ack !== '0) begin
                got = 1;
                got_e = sb.pop_front();
                exp_ack = NREQ'(1 << got_e.idx);
                vectors++;
                if (req_ack !== exp_ack) begin
                    miscompares++;
                    $display("FAIL %s ack: got %b want %b", nm, req_ack, exp_ack);
                end
                if (got_e.chk) begin
                    vectors++;
                    if (req_rdd !== got_e.rdd) begin
                        miscompares++;
                        $display("FAIL %s rdd: got %h want %h", nm, req_rdd, got_e.rdd);
                    end
                end
                vectors++;
                if (n != 3) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d want 3", nm, n);
                end
                vectors++;
                if (ce_n != 1) begin
                    miscompares++;
                    $display("FAIL %s ce_cycles: got %0d want 1", nm, ce_n);
                end
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no ack want ack", nm);
            sb.delete();
        end
        @(posedge reg_clk); #1;
        req_vld[idx] = 1'b0;
        req_we[idx*BW +: BW] = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge reg_clk);
        vectors++;
        if (reg_ce !== 1'b0 || reg_we !== '0 || req_ack !== '0) begin
            miscompares++;
            $display("FAIL reset ctl: got ce=%b we=%h ack=%b want 0", reg_ce, reg_we, req_ack);
        end
        vectors++;
        if (reg_addr !== '0 || reg_wrd !== '0 || req_rdd !== '0) begin
            miscompares++;
            $display("FAIL reset data: got addr=%h wrd=%h rdd=%h want 0", reg_addr, reg_wrd, req_rdd);
        end
        @(posedge reg_clk); #1;
        sys_rst = 1'b0;
    endtask

    task automatic test_write_read();
        single_txn("write0", 0, 4'hF, 12'h003, 32'hDEAD_BEEF, 1'b0);
        single_txn("readback0", 0, 4'h0, 12'h003, 32'h0, 1'b0);
        preload(4'd5, 32'h1234_5678);
        single_txn("read1", 1, 4'h0, 12'h005, 32'h0, 1'b0);
    endtask

    task automatic test_partial_write();
        preload(4'd2, 32'h0BAD_F00D);
        single_txn("partial", 0, 4'b0011, 12'h002, 32'hAAAA_5555, 1'b0);
        single_txn("partial_rb", 1, 4'h0, 12'h002, 32'h0, 1'b0);
    endtask

    task automatic test_early_drop();
        single_txn("early_drop", 1, 4'h0, 12'h005, 32'h0, 1'b1);
    endtask

    task automatic test_reset_abort();
        int n;
        int acks;
        @(posedge reg_clk); #1;
        drive_req(1, 4'h0, 12'h003, 32'h0);
        n = 0;
        while (reg_ce !== 1'b1 && n < 6) begin
            @(negedge reg_clk);
            n++;
        end
        vectors++;
        if (reg_ce !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_reach_access: got ce=%b want 1", reg_ce);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (reg_ce !== 1'b0 || req_ack !== '0 || req_rdd !== '0 || reg_addr !== '0) begin
            miscompares++;
            $display("FAIL abort_clear: got ce=%b ack=%b rdd=%h addr=%h want 0",
                     reg_ce, req_ack, req_rdd, reg_addr);
        end
        req_vld = '0;
        @(posedge reg_clk); #1;
        sys_rst = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge reg_clk);
            if (req_ack !== '0) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL abort_no_ack: got %0d acks want 0", acks);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        exp_t got_e;
        int n, last;
        logic [NREQ-1:0] exp_ack;
        for (int i = 0; i < 4; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
            e.idx = 0;
`else
            e.idx = i % 2;
`endif
            e.rdd = (e.idx == 0) ? shadow[3] : shadow[5];
            e.chk = 1'b1;
            sb.push_back(e);
        end
        @(posedge reg_clk); #1;
        drive_req(0, 4'h0, 12'h003, 32'h0);
        drive_req(1, 4'h0, 12'h005, 32'h0);
        n = 0;
        last = -1;
        while (sb.size() > 0 && n < 30) begin
            @(negedge reg_clk);
            n++;
            if (req_ack !== '0) begin
                got_e = sb.pop_front();
                exp_ack = NREQ'(1 << got_e.idx);
                vectors++;
                if (req_ack !== exp_ack) begin
                    miscompares++;
                    $display("FAIL contention ack: got %b want %b", req_ack, exp_ack);
                end
                vectors++;
                if (req_rdd !== got_e.rdd) begin
                    miscompares++;
                    $display("FAIL contention rdd: got %h want %h", req_rdd, got_e.rdd);
                end
                if (last >= 0) begin
                    vectors++;
                    if (n - last != 3) begin
                        miscompares++;
                        $display("FAIL contention spacing: got %0d want 3", n - last);
                    end
                end
                last = n;
            end
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL contention timeout: got %0d acks pending want 0", sb.size());
            sb.delete();
        end
        @(posedge reg_clk); #1;
        req_vld = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_early_drop();
        test_reset_abort();
        test_contention();
        repeat (3) @(posedge reg_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
